// File: rtl/motion_box_if.sv
// Pixel-stream and bounding-box result bundle for motion_box_extract.
// The master side drives the binarized difference stream; the slave side returns the latched box.
interface motion_box_if;
  logic        pre_img_vsync;
  logic        pre_img_hsync;
  logic        pre_img_valid;
  logic [7:0]  pre_img_data;
  logic        box_flag;
  logic [10:0] top_edge;
  logic [10:0] bottom_edge;
  logic [10:0] left_edge;
  logic [10:0] right_edge;
  logic [19:0] pix_count;

  modport master (
    output pre_img_vsync, pre_img_hsync, pre_img_valid, pre_img_data,
    input  box_flag, top_edge, bottom_edge, left_edge, right_edge, pix_count
  );

  modport slave (
    input  pre_img_vsync, pre_img_hsync, pre_img_valid, pre_img_data,
    output box_flag, top_edge, bottom_edge, left_edge, right_edge, pix_count
  );
endinterface

// File: rtl/motion_box_extract.sv
// Per-frame bounding box of motion pixels; frame N's box is latched at frame N+1's vsync.
// Optional BOX_MARGIN_EN expands the latched box by MARGIN pixels, clamped to the image.
module motion_box_extract #(
  parameter int unsigned IMG_W      = 1280,
  parameter int unsigned IMG_H      = 720,
  parameter logic [7:0]  THRESH     = 8'd128,
  parameter int unsigned MIN_PIXELS = 20,
  parameter int unsigned MARGIN     = 4
) (
  input  logic         clk,
  input  logic         rst,
  motion_box_if.slave  img_io
);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    ACCUM     = 2'd1
  } state_t;

  localparam logic [10:0] COL_LIM = 11'(IMG_W);
  localparam logic [10:0] COL_MAX = 11'(IMG_W - 1);
  localparam logic [10:0] ROW_LIM = 11'(IMG_H);
  localparam logic [10:0] ROW_MAX = 11'(IMG_H - 1);
  localparam logic [19:0] MIN_CNT = 20'(MIN_PIXELS);
  localparam logic [19:0] CNT_SAT = 20'hF_FFFF;
`ifdef BOX_MARGIN_EN
  localparam logic [11:0] MARGIN_EFF = 12'(MARGIN);
`else
  localparam logic [11:0] MARGIN_EFF = 12'd0;
`endif

  // A zero margin makes both clamps the identity, so the raw box passes through unchanged.
  function automatic logic [10:0] lo_clamp(input logic [10:0] v);
    logic signed [11:0] t;
    t = $signed({1'b0, v}) - $signed(MARGIN_EFF);
    if (t < 12'sd0) begin
      lo_clamp = 11'd0;
    end else begin
      lo_clamp = t[10:0];
    end
  endfunction

  function automatic logic [10:0] hi_clamp(input logic [10:0] v, input logic [10:0] lim);
    logic signed [11:0] t;
    t = $signed({1'b0, v}) + $signed(MARGIN_EFF);
    if (t > $signed({1'b0, lim})) begin
      hi_clamp = lim;
    end else begin
      hi_clamp = t[10:0];
    end
  endfunction

  state_t      state_q, state_d;
  logic        vsync_d_q, valid_d_q;
  logic [10:0] col_q, col_d;
  logic [10:0] row_q, row_d;
  logic [10:0] min_x_q, min_x_d, max_x_q, max_x_d;
  logic [10:0] min_y_q, min_y_d, max_y_q, max_y_d;
  logic [19:0] cnt_q, cnt_d;
  logic        hit_q, hit_d;
  logic        box_flag_q, box_flag_d;
  logic [10:0] top_q, top_d, bottom_q, bottom_d;
  logic [10:0] left_q, left_d, right_q, right_d;
  logic [19:0] pix_count_q, pix_count_d;

  logic vsync_pos_s, valid_neg_s, in_frame_s, motion_s;
  logic unused_hsync_s;

  assign unused_hsync_s = img_io.pre_img_hsync;

  // Edge detection and pixel qualification; a pixel on the vsync_pos cycle is dropped.
  always_comb begin
    vsync_pos_s = img_io.pre_img_vsync & ~vsync_d_q;
    valid_neg_s = ~img_io.pre_img_valid & valid_d_q;
    in_frame_s  = img_io.pre_img_valid && (col_q < COL_LIM) && (row_q < ROW_LIM) && !vsync_pos_s;
    motion_s    = in_frame_s && (img_io.pre_img_data >= THRESH) && (state_q == ACCUM);
  end

  // Column/row position counters, both saturating so overruns cannot wrap back into range.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (vsync_pos_s) begin
      col_d = 11'd0;
      row_d = 11'd0;
    end else if (valid_neg_s) begin
      col_d = 11'd0;
      if (row_q < ROW_LIM) begin
        row_d = row_q + 11'd1;
      end else begin
        row_d = row_q;
      end
    end else if (img_io.pre_img_valid && (col_q < COL_LIM)) begin
      col_d = col_q + 11'd1;
    end else begin
      col_d = col_q;
    end
  end

  // Bounding-box accumulators, cleared on every vsync_pos.
  always_comb begin
    min_x_d = min_x_q;
    max_x_d = max_x_q;
    min_y_d = min_y_q;
    max_y_d = max_y_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    if (vsync_pos_s) begin
      min_x_d = COL_MAX;
      max_x_d = 11'd0;
      min_y_d = ROW_MAX;
      max_y_d = 11'd0;
      cnt_d   = 20'd0;
      hit_d   = 1'b0;
    end else if (motion_s) begin
      min_x_d = (col_q < min_x_q) ? col_q : min_x_q;
      max_x_d = (col_q > max_x_q) ? col_q : max_x_q;
      min_y_d = (row_q < min_y_q) ? row_q : min_y_q;
      max_y_d = (row_q > max_y_q) ? row_q : max_y_q;
      cnt_d   = (cnt_q != CNT_SAT) ? (cnt_q + 20'd1) : cnt_q;
      hit_d   = 1'b1;
    end else begin
      hit_d   = hit_q;
    end
  end

  // Frame FSM and result latch; the first vsync_pos only arms the latch.
  always_comb begin
    state_d     = state_q;
    box_flag_d  = box_flag_q;
    top_d       = top_q;
    bottom_d    = bottom_q;
    left_d      = left_q;
    right_d     = right_q;
    pix_count_d = pix_count_q;
    case (state_q)
      WAIT_SYNC: begin
        if (vsync_pos_s) begin
          state_d = ACCUM;
        end else begin
          state_d = WAIT_SYNC;
        end
      end
      ACCUM: begin
        state_d = ACCUM;
        if (vsync_pos_s) begin
          pix_count_d = cnt_q;
          if (hit_q) begin
            top_d      = lo_clamp(min_y_q);
            bottom_d   = hi_clamp(max_y_q, ROW_MAX);
            left_d     = lo_clamp(min_x_q);
            right_d    = hi_clamp(max_x_q, COL_MAX);
            box_flag_d = (cnt_q >= MIN_CNT);
          end else begin
            top_d      = 11'd0;
            bottom_d   = 11'd0;
            left_d     = 11'd0;
            right_d    = 11'd0;
            box_flag_d = 1'b0;
          end
        end else begin
          pix_count_d = pix_count_q;
        end
      end
      default: begin
        state_d = WAIT_SYNC;
      end
    endcase
  end

  // State, counters, accumulators and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= WAIT_SYNC;
      vsync_d_q   <= 1'b0;
      valid_d_q   <= 1'b0;
      col_q       <= 11'd0;
      row_q       <= 11'd0;
      min_x_q     <= COL_MAX;
      max_x_q     <= 11'd0;
      min_y_q     <= ROW_MAX;
      max_y_q     <= 11'd0;
      cnt_q       <= 20'd0;
      hit_q       <= 1'b0;
      box_flag_q  <= 1'b0;
      top_q       <= 11'd0;
      bottom_q    <= 11'd0;
      left_q      <= 11'd0;
      right_q     <= 11'd0;
      pix_count_q <= 20'd0;
    end else begin
      state_q     <= state_d;
      vsync_d_q   <= img_io.pre_img_vsync;
      valid_d_q   <= img_io.pre_img_valid;
      col_q       <= col_d;
      row_q       <= row_d;
      min_x_q     <= min_x_d;
      max_x_q     <= max_x_d;
      min_y_q     <= min_y_d;
      max_y_q     <= max_y_d;
      cnt_q       <= cnt_d;
      hit_q       <= hit_d;
      box_flag_q  <= box_flag_d;
      top_q       <= top_d;
      bottom_q    <= bottom_d;
      left_q      <= left_d;
      right_q     <= right_d;
      pix_count_q <= pix_count_d;
    end
  end

  assign img_io.box_flag    = box_flag_q;
  assign img_io.top_edge    = top_q;
  assign img_io.bottom_edge = bottom_q;
  assign img_io.left_edge   = left_q;
  assign img_io.right_edge  = right_q;
  assign img_io.pix_count   = pix_count_q;

endmodule
